// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader and its byte receiver.
package uart_boot_loader_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_LEN_LO    = 3'd1,
        ST_LEN_HI    = 3'd2,
        ST_DATA_LO   = 3'd3,
        ST_DATA_HI   = 3'd4,
        ST_CSUM      = 3'd5,
        ST_RUN       = 3'd6,
        ST_ERROR     = 3'd7
    } loader_state_e;

    // Byte receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // The LEN field and the word index need one bit more than the address,
    // so a full image of 2**addr_w words is representable without wrap.
    function automatic int len_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
// Emits a one-cycle byte_valid_o together with the byte and its framing status.
module uart_rx_byte
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Synchronize the asynchronous line (idle high) and keep one sample of history for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: falling edge starts a frame, start bit is re-checked at half a bit, then sample at bit centres.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};   // LSB arrives first
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                    byte_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: holds the CPU in reset, receives a framed program image
// over the boot UART and writes it word by word into the instruction RAM.
// Optional feature macro LOADER_CHECKSUM_EN: when defined, a trailing
// checksum byte is required and verified; otherwise the frame ends after
// the last data word and no sum logic is built.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         ADDR_W       = 12,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         BOOT_WAIT    = 12000000,
    parameter int         BYTE_TIMEOUT = 120000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [15:0]       din_o,
    output logic              w_en_o,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int LEN_W      = len_width(ADDR_W);
    localparam int CMP_W      = (LEN_W > 16) ? LEN_W : 16;
    localparam int BOOT_CNT_W = $clog2(BOOT_WAIT + 1);
    localparam int TO_CNT_W   = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [CMP_W-1:0] LEN_MAX = CMP_W'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e ST_AFTER_DATA = ST_CSUM;
`else
    localparam loader_state_e ST_AFTER_DATA = ST_RUN;
`endif

    // Received byte stream
    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_ferr_s;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .frame_err_o  (rx_ferr_s)
    );

    loader_state_e         state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [7:0]            lo_q, lo_d;
    logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
    logic [15:0]           din_q, din_d;
    logic                  w_en_q, w_en_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  byte_ok_s;
    logic                  sync_ok_s;
    logic                  in_frame_s;
    logic                  timeout_s;
    logic [CMP_W-1:0]      len_full_s;
    logic [LEN_W-1:0]      idx_inc_s;

    // Qualifiers shared by the FSM and the checksum accumulator.
    always_comb begin
        byte_ok_s  = rx_valid_s && !rx_ferr_s;
        sync_ok_s  = byte_ok_s && (rx_byte_s == SYNC_BYTE);
        in_frame_s = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                     (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI) ||
                     (state_q == ST_CSUM);
        timeout_s  = in_frame_s && (to_cnt_q == TO_CNT_W'(BYTE_TIMEOUT - 1));
        len_full_s = CMP_W'({rx_byte_s, len_q[7:0]});
        idx_inc_s  = idx_q + LEN_W'(1);
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running 8-bit sum over LEN and data bytes; a new sync restarts it.
    always_comb begin
        sum_d = sum_q;
        if (sync_ok_s && ((state_q == ST_WAIT_SYNC) || (state_q == ST_ERROR))) begin
            sum_d = 8'h00;
        end else if (byte_ok_s && !timeout_s &&
                     ((state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI))) begin
            sum_d = sum_q + rx_byte_s;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Loader next-state logic, counters and write-port decode.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        boot_cnt_d = boot_cnt_q;
        to_cnt_d   = '0;
        w_addr_d   = w_addr_q;
        din_d      = din_q;
        w_en_d     = 1'b0;

        // Inter-byte idle counter runs only inside a frame and clears on every byte.
        if (in_frame_s && !rx_valid_s) begin
            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
        end else begin
            to_cnt_d = '0;
        end

        case (state_q)
            ST_WAIT_SYNC: begin
                if (sync_ok_s) begin
                    state_d = ST_LEN_LO;
                    idx_d   = '0;
                end else if (boot_cnt_q == BOOT_CNT_W'(BOOT_WAIT)) begin
                    state_d = ST_RUN;       // no image offered: boot what is in RAM
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
                end
            end
            ST_LEN_LO: begin
                if (timeout_s) begin
                    state_d = ST_ERROR;
                end else if (rx_valid_s) begin
                    if (rx_ferr_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = LEN_W'(rx_byte_s);
                        state_d = ST_LEN_HI;
                    end
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (timeout_s) begin
                    state_d = ST_ERROR;
                end else if (rx_valid_s) begin
                    if (rx_ferr_s || (len_full_s > LEN_MAX)) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d = len_full_s[LEN_W-1:0];
                        if (len_full_s == '0) begin
                            state_d = ST_AFTER_DATA;
                        end else begin
                            state_d = ST_DATA_LO;
                        end
                    end
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_DATA_LO: begin
                if (timeout_s) begin
                    state_d = ST_ERROR;
                end else if (rx_valid_s) begin
                    if (rx_ferr_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        lo_d    = rx_byte_s;
                        state_d = ST_DATA_HI;
                    end
                end else begin
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_HI: begin
                if (timeout_s) begin
                    state_d = ST_ERROR;
                end else if (rx_valid_s) begin
                    if (rx_ferr_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        w_en_d   = 1'b1;
                        w_addr_d = idx_q[ADDR_W-1:0];
                        din_d    = {rx_byte_s, lo_q};
                        idx_d    = idx_inc_s;
                        if (idx_inc_s == len_q) begin
                            state_d = ST_AFTER_DATA;
                        end else begin
                            state_d = ST_DATA_LO;
                        end
                    end
                end else begin
                    state_d = ST_DATA_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (timeout_s) begin
                    state_d = ST_ERROR;
                end else if (rx_valid_s) begin
                    if (rx_ferr_s || ((sum_q + rx_byte_s) != 8'h00)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_RUN: begin
                state_d = ST_RUN;           // only reset leaves RUN
            end
            ST_ERROR: begin
                if (sync_ok_s) begin
                    state_d = ST_LEN_LO;
                    idx_d   = '0;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_ERROR;         // unreachable encodings fail safe
            end
        endcase

        cpu_reset_d = (state_d != ST_RUN);
        done_d      = (state_d == ST_RUN);
        err_d       = (state_d == ST_ERROR);
    end

    // Loader state, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_WAIT_SYNC;
            len_q       <= '0;
            idx_q       <= '0;
            lo_q        <= 8'h00;
            boot_cnt_q  <= '0;
            to_cnt_q    <= '0;
            w_addr_q    <= '0;
            din_q       <= 16'h0000;
            w_en_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            boot_cnt_q  <= boot_cnt_d;
            to_cnt_q    <= to_cnt_d;
            w_addr_q    <= w_addr_d;
            din_q       <= din_d;
            w_en_q      <= w_en_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign w_addr_o    = w_addr_q;
    assign din_o       = din_q;
    assign w_en_o      = w_en_q;
    assign cpu_reset_o = cpu_reset_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected RAM writes are queued by the
// stimulus and popped by a monitor whenever w_en_o pulses.
module tb_uart_boot_loader;

    localparam int CPB = 4;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [11:0] w_addr;
    logic [15:0] din;
    logic        w_en;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];

    uart_boot_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (12),
        .SYNC_BYTE    (8'hA5),
        .BOOT_WAIT    (2000),
        .BYTE_TIMEOUT (200)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .w_addr_o    (w_addr),
        .din_o       (din),
        .w_en_o      (w_en),
        .cpu_reset_o (cpu_reset),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && w_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected actual=addr %h data %h required=no write", w_addr, din);
                end else begin
                    e = exp_q.pop_front();
                    if (w_addr !== e.addr || din !== e.data) begin
                        errors++;
                        $display("FAIL wr_data actual=addr %h data %h required=addr %h data %h",
                                 w_addr, din, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Bounded wait for {cpu_reset, done, err}; an expired budget is a failure.
    task automatic expect_status(input string name, input logic [2:0] exp, input int budget);
        int n = 0;
        while (n < budget && {cpu_reset, done, err} !== exp) begin
            @(negedge clk);
            n++;
        end
        check_val(name, 32'({cpu_reset, done, err}), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] b [0:7], input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], 1'b1);
        end
    endtask

    // Sum of 02 00 34 12 CD AB is 0xC0, so 0x40 closes the frame to zero.
    localparam logic [7:0] CS_GOOD = 8'h40;
    localparam logic [7:0] CS_BAD  = 8'h41;
`ifdef LOADER_CHECKSUM_EN
    localparam int FRAME_N = 8;
`else
    localparam int FRAME_N = 7;
`endif

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        check_val("rst_w_addr", 32'(w_addr), 32'h0);
        check_val("rst_din", 32'(din), 32'h0);
        check_val("rst_w_en", 32'(w_en), 32'h0);
        check_val("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check_val("rst_done", 32'(done), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // Good two-word frame
        do_reset();
        push_wr(12'h000, 16'h1234);
        push_wr(12'h001, 16'hABCD);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, CS_GOOD}, FRAME_N);
        expect_status("good_run", 3'b010, 40);
        check_val("good_wr_drained", 32'(exp_q.size()), 32'h0);
        // RUN ignores further rx traffic
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00}, 5);
        check_val("run_ignores_rx", 32'({cpu_reset, done, err}), 32'b010);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum, then recovery by a fresh correct frame
        do_reset();
        push_wr(12'h000, 16'h1234);
        push_wr(12'h001, 16'hABCD);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, CS_BAD}, 8);
        expect_status("bad_csum_err", 3'b101, 40);
        push_wr(12'h000, 16'h1234);
        push_wr(12'h001, 16'hABCD);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, CS_GOOD}, 8);
        expect_status("recover_run", 3'b010, 40);
        check_val("recover_wr_drained", 32'(exp_q.size()), 32'h0);
`else
        // Empty image ends right after LEN_HI
        do_reset();
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        expect_status("len0_run", 3'b010, 40);
`endif

        // Boot window expiry with an idle line
        do_reset();
        repeat (1990) @(negedge clk);
        check_val("boot_hold_1990", 32'({cpu_reset, done, err}), 32'b100);
        expect_status("boot_release", 3'b010, 30);

        // Inter-byte timeout inside DATA_HI
        do_reset();
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        repeat (150) @(negedge clk);
        check_val("timeout_not_early", 32'(err), 32'h0);
        expect_status("timeout_err", 3'b101, 100);
        check_val("timeout_no_wr", 32'(exp_q.size()), 32'h0);

        // LEN = 4097 is rejected right after LEN_HI
        do_reset();
        send_seq('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        expect_status("len_4097_err", 3'b101, 10);

        // LEN = 4096 is the largest legal length
        do_reset();
        send_seq('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        repeat (10) @(negedge clk);
        check_val("len_4096_ok", 32'({cpu_reset, done, err}), 32'b100);

        // Framing error inside a frame
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b0);
        expect_status("ferr_in_frame", 3'b101, 10);

        // Framing error while waiting for sync is discarded
        do_reset();
        send_byte(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        check_val("ferr_wait_sync", 32'({cpu_reset, done, err}), 32'b100);
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, FRAME_N - 4);
        expect_status("ferr_then_run", 3'b010, 40);

        // Asynchronous reset in the middle of DATA_HI
        do_reset();
        push_wr(12'h000, 16'h1234);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'h00, 8'h00}, 6);
        check_val("pre_rst_din", 32'(din), 32'h1234);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_din", 32'(din), 32'h0);
        check_val("async_rst_status", 32'({w_en, cpu_reset, done, err}), 32'b0100);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, FRAME_N - 4);
        expect_status("post_rst_run", 3'b010, 40);
        check_val("final_wr_drained", 32'(exp_q.size()), 32'h0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
